// File: rtl/cic_pkg.sv
// Shared CIC helpers: configuration limits, counter sizing and the W -> OW output
// narrowing used by the comb section.
package cic_pkg;

  localparam int CIC_MAX_N = 8;
  localparam int CIC_MAX_M = 4;
  localparam int CIC_ACC_W = 64;

  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  // Narrow a sign-extended w-bit value to ow bits: truncate, or round half-up and clamp.
  function automatic logic signed [CIC_ACC_W-1:0] sat_round(
    input logic signed [CIC_ACC_W-1:0] value,
    input int                          w,
    input int                          ow,
    input logic                        round_en
  );
    logic signed [CIC_ACC_W-1:0] t_s;
    logic signed [CIC_ACC_W-1:0] q_s;
    logic signed [CIC_ACC_W-1:0] max_s;
    logic signed [CIC_ACC_W-1:0] min_s;
    max_s = (64'sd1 <<< (ow - 1)) - 64'sd1;
    min_s = -(64'sd1 <<< (ow - 1));
    t_s   = value;
    if (ow >= w) begin
      q_s = value;
    end else if (round_en) begin
      t_s = value + (64'sd1 <<< (w - ow - 1));
      q_s = t_s >>> (w - ow);
      if (q_s > max_s) begin
        q_s = max_s;
      end else if (q_s < min_s) begin
        q_s = min_s;
      end else begin
        q_s = t_s >>> (w - ow);
      end
    end else begin
      q_s = t_s >>> (w - ow);
    end
    return q_s;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb stage: y = x - x delayed by M accepted samples, plus its valid register.
module cic_comb_stage #(
  parameter int W = 16,
  parameter int M = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_ce,
  input  logic signed [W-1:0] i_data,
  input  logic                i_valid,
  output logic signed [W-1:0] o_data,
  output logic                o_valid
);

  logic signed [W-1:0] dly_r [M];
  logic signed [W-1:0] data_r;
  logic                valid_r;

  // Delay line and difference advance only on valid samples, so the comb runs at the sample rate.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < M; i++) begin
        dly_r[i] <= '0;
      end
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (i_ce) begin
      valid_r <= i_valid;
      if (i_valid) begin
        data_r   <= i_data - dly_r[M-1];
        dly_r[0] <= i_data;
        for (int i = 1; i < M; i++) begin
          dly_r[i] <= dly_r[i-1];
        end
      end
    end
  end

  assign o_data  = data_r;
  assign o_valid = valid_r;

endmodule

// File: rtl/cic_comb.sv
// N-stage CIC comb section, (1 - z^-M)^N, fully pipelined, followed by a registered
// truncate or round/saturate stage from W to OW bits.
module cic_comb
  import cic_pkg::*;
#(
  parameter int W     = 16,
  parameter int OW    = 16,
  parameter int N     = 3,
  parameter int M     = 1,
  parameter int ROUND = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic signed [W-1:0]  i_data,
  input  logic                 i_valid,
  output logic signed [OW-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_primed
);

  localparam int             NM   = N * M;
  localparam int             CW   = cnt_width(NM);
  localparam logic [CW-1:0]  NM_C = CW'(NM);

  logic [N:0][W-1:0]    stg_data_s;
  logic [N:0]           stg_valid_s;
  logic signed [W-1:0]  y_last_s;
  logic signed [OW-1:0] out_s;
  logic signed [OW-1:0] data_r;
  logic                 valid_r;
  logic [CW-1:0]        cnt_r;
  logic                 primed_r;

  assign stg_data_s[0]  = i_data;
  assign stg_valid_s[0] = i_valid;

  for (genvar s = 0; s < N; s++) begin : g_stage
    cic_comb_stage #(.W(W), .M(M)) u_stage (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_ce    (i_ce),
      .i_data  (stg_data_s[s]),
      .i_valid (stg_valid_s[s]),
      .o_data  (stg_data_s[s+1]),
      .o_valid (stg_valid_s[s+1])
    );
  end

  assign y_last_s = stg_data_s[N];
  assign out_s    = OW'(sat_round(CIC_ACC_W'(y_last_s), W, OW, (ROUND != 0)));

  // Output register: one-cycle strobe per comb result, frozen while i_ce is low.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (i_ce) begin
      valid_r <= stg_valid_s[N];
      if (stg_valid_s[N]) begin
        data_r <= out_s;
      end
    end
  end

  // Accepted-sample counter; primed rises with the sample that fills every delay line.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_r    <= '0;
      primed_r <= 1'b0;
    end else if (i_ce && i_valid && (cnt_r != NM_C)) begin
      cnt_r    <= cnt_r + CW'(1);
      primed_r <= (cnt_r == (NM_C - CW'(1)));
    end
  end

  assign o_data   = data_r;
  assign o_valid  = valid_r;
  assign o_primed = primed_r;

endmodule
